// File: rtl/netcope_hdr_strip_pkg.sv
// Shared types and helpers for the NetCOPE header stripper.
package netcope_hdr_strip_pkg;

  typedef enum logic [1:0] {
    S_HDR,
    S_FIRST,
    S_BODY
  } state_e;

  function automatic int unsigned drem_width(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/netcope_hdr_strip.sv
// Removes the NetCOPE header part (part 0) from FrameLink frames, captures the first
// header word and counts dropped header-only frames.
module netcope_hdr_strip
  import netcope_hdr_strip_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DREM_WIDTH = drem_width(DATA_WIDTH)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] RX_DATA,
  input  logic [DREM_WIDTH-1:0] RX_REM,
  input  logic                  RX_SOF_N,
  input  logic                  RX_SOP_N,
  input  logic                  RX_EOP_N,
  input  logic                  RX_EOF_N,
  input  logic                  RX_SRC_RDY_N,
  output logic                  RX_DST_RDY_N,
  output logic [DATA_WIDTH-1:0] TX_DATA,
  output logic [DREM_WIDTH-1:0] TX_REM,
  output logic                  TX_SOF_N,
  output logic                  TX_SOP_N,
  output logic                  TX_EOP_N,
  output logic                  TX_EOF_N,
  output logic                  TX_SRC_RDY_N,
  input  logic                  TX_DST_RDY_N,
  output logic [DATA_WIDTH-1:0] HDR_DATA,
  output logic                  HDR_VLD,
  output logic [31:0]           CNT_DROP,
  input  logic                  CNT_CLR
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] hdr_data_q;
  logic                  hdr_vld_q;
  logic [31:0]           cnt_drop_q;
  logic                  hdr_sof;
  logic                  hdr_drop;

  always_comb begin
    state_d      = state_q;
    RX_DST_RDY_N = 1'b0;
    TX_DATA      = RX_DATA;
    TX_REM       = RX_REM;
    TX_SRC_RDY_N = 1'b1;
    TX_SOF_N     = 1'b1;
    TX_SOP_N     = 1'b1;
    TX_EOP_N     = 1'b1;
    TX_EOF_N     = 1'b1;
    hdr_sof      = 1'b0;
    hdr_drop     = 1'b0;
    unique case (state_q)
      S_HDR: begin
        // Header words are always accepted, so RX valid alone means a transfer.
        if (!RX_SRC_RDY_N) begin
          hdr_sof = !RX_SOF_N;
          if (!RX_EOP_N) begin
            if (RX_EOF_N) begin
              state_d = S_FIRST;
            end else begin
              hdr_drop = 1'b1;
            end
          end
        end
      end
      S_FIRST, S_BODY: begin
        RX_DST_RDY_N = TX_DST_RDY_N;
        TX_SRC_RDY_N = RX_SRC_RDY_N;
        TX_SOF_N     = (state_q != S_FIRST);
        TX_SOP_N     = RX_SOP_N;
        TX_EOP_N     = RX_EOP_N;
        TX_EOF_N     = RX_EOF_N;
        if (!RX_SRC_RDY_N && !TX_DST_RDY_N) begin
          if (!RX_EOF_N) begin
            state_d = S_HDR;
          end else if (state_q == S_FIRST) begin
            state_d = S_BODY;
          end
        end
      end
      default: state_d = S_HDR;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_HDR;
      hdr_data_q <= '0;
      hdr_vld_q  <= 1'b0;
      cnt_drop_q <= '0;
    end else begin
      state_q   <= state_d;
      hdr_vld_q <= hdr_sof;
      if (hdr_sof) begin
        hdr_data_q <= RX_DATA;
      end
      // Clear takes priority over a coincident drop.
      if (CNT_CLR) begin
        cnt_drop_q <= '0;
      end else if (hdr_drop) begin
        cnt_drop_q <= cnt_drop_q + 32'd1;
      end
    end
  end

  assign HDR_DATA = hdr_data_q;
  assign HDR_VLD  = hdr_vld_q;
  assign CNT_DROP = cnt_drop_q;

endmodule

// File: tb/tb_netcope_hdr_strip.sv
// Self-checking bench for netcope_hdr_strip: directed frames plus randomized frames
// compared against a queue-based frame model.
module tb_netcope_hdr_strip;

  typedef struct packed {
    logic [63:0] data;
    logic [2:0]  rem;
    logic        sof;
    logic        sop;
    logic        eop;
    logic        eof;
  } fl_t;

  typedef struct {
    fl_t w;
    bit  hdr;
  } rx_t;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [63:0] RX_DATA = '0;
  logic [2:0]  RX_REM = '0;
  logic        RX_SOF_N = 1'b1, RX_SOP_N = 1'b1, RX_EOP_N = 1'b1, RX_EOF_N = 1'b1;
  logic        RX_SRC_RDY_N = 1'b1;
  logic        RX_DST_RDY_N;
  logic [63:0] TX_DATA;
  logic [2:0]  TX_REM;
  logic        TX_SOF_N, TX_SOP_N, TX_EOP_N, TX_EOF_N, TX_SRC_RDY_N;
  logic        TX_DST_RDY_N = 1'b0;
  logic [63:0] HDR_DATA;
  logic        HDR_VLD;
  logic [31:0] CNT_DROP;
  logic        CNT_CLR = 1'b0;

  netcope_hdr_strip #(.DATA_WIDTH(64)) dut (
    .CLK(CLK), .RESET(RESET),
    .RX_DATA(RX_DATA), .RX_REM(RX_REM), .RX_SOF_N(RX_SOF_N), .RX_SOP_N(RX_SOP_N),
    .RX_EOP_N(RX_EOP_N), .RX_EOF_N(RX_EOF_N), .RX_SRC_RDY_N(RX_SRC_RDY_N),
    .RX_DST_RDY_N(RX_DST_RDY_N),
    .TX_DATA(TX_DATA), .TX_REM(TX_REM), .TX_SOF_N(TX_SOF_N), .TX_SOP_N(TX_SOP_N),
    .TX_EOP_N(TX_EOP_N), .TX_EOF_N(TX_EOF_N), .TX_SRC_RDY_N(TX_SRC_RDY_N),
    .TX_DST_RDY_N(TX_DST_RDY_N),
    .HDR_DATA(HDR_DATA), .HDR_VLD(HDR_VLD), .CNT_DROP(CNT_DROP), .CNT_CLR(CNT_CLR)
  );

  always #5 CLK = ~CLK;

  int          tests = 0;
  int          fails = 0;
  int          tx_cnt = 0;
  int          pulses = 0;
  int unsigned exp_drop = 0;
  bit          bp_en = 1'b0;
  bit          idle_en = 1'b0;
  bit          cur_is_hdr = 1'b0;
  fl_t         last_tx = '0;
  fl_t         exp_q[$];
  logic [63:0] exp_hdr[$];
  rx_t         rx_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output backpressure generator.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      TX_DST_RDY_N = bp_en ? 1'($urandom_range(1)) : 1'b0;
    end
  end

  // Monitor: samples on the falling edge, when all inputs are settled.
  always @(negedge CLK) begin
    if (!RX_SRC_RDY_N && cur_is_hdr) check("hdr_no_stall", 128'(RX_DST_RDY_N), 128'd0);
    if (!RX_SRC_RDY_N && !RX_DST_RDY_N && !RX_SOF_N && !cur_is_hdr) begin
      fails++;
      $error("FAIL rx_sof_outside_hdr: observed sof=0 expected header phase");
    end
    if (!TX_SRC_RDY_N && !TX_DST_RDY_N) begin
      tx_cnt++;
      last_tx = '{TX_DATA, TX_REM, TX_SOF_N, TX_SOP_N, TX_EOP_N, TX_EOF_N};
      if (exp_q.size() == 0) check("tx_unexpected", 128'd1, 128'd0);
      else check("tx_word", 128'(last_tx), 128'(exp_q.pop_front()));
    end
    if (HDR_VLD) begin
      pulses++;
      if (exp_hdr.size() == 0) check("hdr_vld_unexpected", 128'd1, 128'd0);
      else check("hdr_data", 128'(HDR_DATA), 128'(exp_hdr.pop_front()));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Build one frame into rx_q and its expected stripped form into exp_q.
  // nparts = 0 gives a header-only frame; plen > 0 fixes every payload part length.
  task automatic build_frame(input int hdr_len, input int nparts, input int plen,
                             input logic [63:0] hdr0, input int last_rem);
    rx_t r;
    fl_t e;
    int  len;
    for (int i = 0; i < hdr_len; i++) begin
      r.hdr    = 1'b1;
      r.w.data = (i == 0) ? hdr0 : rnd64();
      r.w.rem  = 3'($urandom);
      r.w.sof  = (i != 0);
      r.w.sop  = (i != 0);
      r.w.eop  = (i != hdr_len - 1);
      r.w.eof  = !(nparts == 0 && i == hdr_len - 1);
      rx_q.push_back(r);
    end
    for (int p = 0; p < nparts; p++) begin
      len = (plen > 0) ? plen : int'($urandom_range(4, 1));
      for (int j = 0; j < len; j++) begin
        r.hdr    = 1'b0;
        r.w.data = rnd64();
        r.w.sof  = 1'b1;
        r.w.sop  = (j != 0);
        r.w.eop  = (j != len - 1);
        r.w.eof  = !(p == nparts - 1 && j == len - 1);
        r.w.rem  = (!r.w.eof && last_rem >= 0) ? 3'(last_rem) : 3'($urandom);
        rx_q.push_back(r);
        e     = r.w;
        e.sof = !(p == 0 && j == 0);
        exp_q.push_back(e);
      end
    end
    if (nparts == 0) exp_drop++;
  endtask

  task automatic send_word(input fl_t w, input bit is_hdr, input bit clr);
    bit acc = 1'b0;
    int n = 0;
    if (idle_en && $urandom_range(3) == 0) idle(1);
    RX_DATA      = w.data;
    RX_REM       = w.rem;
    RX_SOF_N     = w.sof;
    RX_SOP_N     = w.sop;
    RX_EOP_N     = w.eop;
    RX_EOF_N     = w.eof;
    RX_SRC_RDY_N = 1'b0;
    CNT_CLR      = clr;
    cur_is_hdr   = is_hdr;
    while (!acc && n < 200) begin
      @(negedge CLK);
      acc = !RX_DST_RDY_N;
      if (acc && is_hdr && !w.sof) exp_hdr.push_back(w.data);
      @(posedge CLK);
      #1;
      n++;
    end
    if (!acc) check("rx_accept_timeout", 128'd0, 128'd1);
    RX_SRC_RDY_N = 1'b1;
    RX_SOF_N     = 1'b1;
    CNT_CLR      = 1'b0;
    cur_is_hdr   = 1'b0;
  endtask

  task automatic send_n(input int n, input bit clr_last);
    rx_t r;
    for (int i = 0; i < n && rx_q.size() > 0; i++) begin
      r = rx_q.pop_front();
      send_word(r.w, r.hdr, clr_last && rx_q.size() == 0);
    end
  endtask

  int          tx0, p0;
  logic [63:0] h;

  initial begin
    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check("rst_tx_src_rdy", 128'(TX_SRC_RDY_N), 128'd1);
    check("rst_rx_dst_rdy", 128'(RX_DST_RDY_N), 128'd0);
    RESET = 1'b0;
    idle(1);
    check("rst_hdr_data", 128'(HDR_DATA), 128'd0);
    check("rst_hdr_vld", 128'(HDR_VLD), 128'd0);
    check("rst_cnt_drop", 128'(CNT_DROP), 128'd0);
    check("rst_tx_src_rdy_after", 128'(TX_SRC_RDY_N), 128'd1);

    // 1-word header, 3-word payload
    tx0 = tx_cnt; p0 = pulses;
    build_frame(1, 1, 3, 64'hA5A5_0000_0000_0001, -1);
    send_n(rx_q.size(), 1'b0);
    idle(2);
    check("t1_tx_words", 128'(tx_cnt - tx0), 128'd3);
    check("t1_hdr_data", 128'(HDR_DATA), 128'hA5A5_0000_0000_0001);
    check("t1_pulses", 128'(pulses - p0), 128'd1);

    // 2-word header, 1-word payload with REM=3
    tx0 = tx_cnt;
    h = rnd64();
    build_frame(2, 1, 1, h, 3);
    send_n(rx_q.size(), 1'b0);
    idle(2);
    check("t2_tx_words", 128'(tx_cnt - tx0), 128'd1);
    check("t2_tx_flags", 128'({last_tx.sof, last_tx.sop, last_tx.eop, last_tx.eof}), 128'd0);
    check("t2_tx_rem", 128'(last_tx.rem), 128'd3);
    check("t2_hdr_data", 128'(HDR_DATA), 128'(h));

    // Header-only frame
    tx0 = tx_cnt; p0 = pulses;
    build_frame(1, 0, 0, rnd64(), -1);
    send_n(rx_q.size(), 1'b0);
    idle(2);
    check("t3_tx_words", 128'(tx_cnt - tx0), 128'd0);
    check("t3_cnt_drop", 128'(CNT_DROP), 128'd1);
    check("t3_pulses", 128'(pulses - p0), 128'd1);

    // Randomized frames with backpressure and input idles
    bp_en = 1'b1; idle_en = 1'b1;
    for (int f = 0; f < 100; f++) begin
      build_frame(int'($urandom_range(3, 1)), int'($urandom_range(3)), 0, rnd64(), -1);
      send_n(rx_q.size(), 1'b0);
    end
    idle(2);
    check("rnd_cnt_drop", 128'(CNT_DROP), 128'(exp_drop));
    check("rnd_exp_q_empty", 128'(exp_q.size()), 128'd0);
    check("rnd_exp_hdr_empty", 128'(exp_hdr.size()), 128'd0);

    // Reset in the middle of a payload
    idle_en = 1'b0;
    build_frame(1, 1, 5, rnd64(), -1);
    send_n(3, 1'b0);
    exp_q.delete();
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    exp_drop = 0;
    check("mid_rst_tx_src_rdy", 128'(TX_SRC_RDY_N), 128'd1);
    check("mid_rst_rx_dst_rdy", 128'(RX_DST_RDY_N), 128'd0);
    check("mid_rst_hdr_data", 128'(HDR_DATA), 128'd0);
    check("mid_rst_cnt_drop", 128'(CNT_DROP), 128'd0);
    foreach (rx_q[i]) rx_q[i].hdr = 1'b1;
    tx0 = tx_cnt;
    send_n(rx_q.size(), 1'b0);
    exp_drop = 1;
    idle(2);
    check("mid_rst_absorbed", 128'(tx_cnt - tx0), 128'd0);
    check("mid_rst_tail_drop", 128'(CNT_DROP), 128'(exp_drop));
    tx0 = tx_cnt;
    build_frame(2, 2, 2, rnd64(), -1);
    send_n(rx_q.size(), 1'b0);
    idle(2);
    check("post_rst_tx_words", 128'(tx_cnt - tx0), 128'd4);

    // CNT_CLR against a coincident drop
    bp_en = 1'b0;
    CNT_CLR = 1'b1;
    idle(1);
    CNT_CLR = 1'b0;
    exp_drop = 0;
    check("clr_cnt_drop", 128'(CNT_DROP), 128'd0);
    for (int f = 0; f < 5; f++) begin
      build_frame(1, 0, 0, rnd64(), -1);
      send_n(rx_q.size(), 1'b0);
    end
    idle(1);
    check("clr_pre_cnt5", 128'(CNT_DROP), 128'd5);
    build_frame(2, 0, 0, rnd64(), -1);
    send_n(rx_q.size(), 1'b1);
    idle(2);
    check("clr_wins", 128'(CNT_DROP), 128'd0);
    check("end_exp_q_empty", 128'(exp_q.size()), 128'd0);
    check("end_exp_hdr_empty", 128'(exp_hdr.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/netcope_hdr_strip.md
# netcope_hdr_strip

Downstream companion of the NetCOPE adder on the FrameLink path. It consumes multi-part FrameLink frames whose part 0 is the NetCOPE header, and removes that part. The remaining parts are forwarded as a well-formed frame, with SOF moved to the first word of part 1. The first header word is captured to a side register, and header-only frames are dropped and counted.

## Interface
Parameters:
- DATA_WIDTH, 64: FrameLink data width in bits; power of two, 16..128.
- DREM_WIDTH, log2(DATA_WIDTH/8): width of the RX/TX DREM fields.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- RX_DATA  in  DATA_WIDTH  input data word.
- RX_REM  in  DREM_WIDTH  index of the last valid byte (meaningful on EOP).
- RX_SOF_N, RX_SOP_N, RX_EOP_N, RX_EOF_N  in  1 each  active-low frame/part delimiters.
- RX_SRC_RDY_N  in  1  active-low input word valid.
- RX_DST_RDY_N  out  1  active-low input ready.
- TX_DATA, TX_REM, TX_SOF_N, TX_SOP_N, TX_EOP_N, TX_EOF_N, TX_SRC_RDY_N  out  as RX  output FrameLink.
- TX_DST_RDY_N  in  1  active-low output ready.
- HDR_DATA  out  DATA_WIDTH  first word of the last stripped header.
- HDR_VLD  out  1  one-cycle pulse when HDR_DATA is updated.
- CNT_DROP  out  32  number of header-only frames dropped.
- CNT_CLR  in  1  synchronous clear of CNT_DROP.

## Operation
- An RX transfer occurs when RX_SRC_RDY_N=0 and RX_DST_RDY_N=0. A TX transfer occurs when TX_SRC_RDY_N=0 and TX_DST_RDY_N=0.
- FSM states:
  - S_HDR: reset state.
  - S_FIRST: next word is the first payload word.
  - S_BODY.
- S_HDR:
  - RX_DST_RDY_N=0 unconditionally; header words are consumed without backpressure.
  - TX_SRC_RDY_N=1.
  - On a transfer with RX_SOF_N=0, RX_DATA is latched into HDR_DATA and HDR_VLD is pulsed.
  - On a transfer with EOP=0 and EOF=1, the FSM goes to S_FIRST.
  - On a transfer with EOP=0 and EOF=0 (header-only frame), the frame is dropped, CNT_DROP is incremented, and the FSM stays in S_HDR.
- S_FIRST and S_BODY:
  - Pass-through: TX_DATA=RX_DATA, TX_REM=RX_REM, TX_SRC_RDY_N=RX_SRC_RDY_N, RX_DST_RDY_N=TX_DST_RDY_N.
  - SOP, EOP and EOF are passed unchanged.
  - TX_SOF_N=0 in S_FIRST, 1 in S_BODY.
  - RX_SOF_N is never forwarded.
  - On a transfer with EOF=0, the FSM goes to S_HDR.
  - On a transfer in S_FIRST with EOF=1, the FSM goes to S_BODY.
- No input protocol checking is done. RX_SOF_N=0 outside S_HDR is a protocol violation with undefined output; the bench flags it with an assertion.
- CNT_DROP wraps modulo 2^32. If CNT_CLR and an increment occur in the same cycle, CNT_CLR wins and the counter becomes 0.
- HDR_DATA holds its value until the next header SOF transfer.

## Timing
- Data path latency is zero (combinational pass-through). Only the FSM state, HDR_DATA, HDR_VLD and CNT_DROP are registered.
- HDR_VLD is high in the cycle after the header SOF transfer, for exactly one cycle. HDR_DATA is valid in the same cycle as the pulse.
- CNT_DROP updates in the cycle after the dropping EOF transfer.
- Reset values:
  - FSM = S_HDR.
  - HDR_DATA = 0, HDR_VLD = 0, CNT_DROP = 0.
  - Therefore TX_SRC_RDY_N=1 and RX_DST_RDY_N=0 during and after reset.
- RESET mid-frame returns the FSM to S_HDR; the rest of the frame in progress is treated as header and discarded.
- Output stalls (TX_DST_RDY_N=1) hold the FSM. Input idles (RX_SRC_RDY_N=1) hold the FSM.
- Back-to-back frames at full rate are supported. Throughput is one word per cycle, except that header words occupy input cycles with no TX output.

## Structure
- Shared package netcope_hdr_strip_pkg contains:
  - the state enum typedef (S_HDR, S_FIRST, S_BODY);
  - a constant function computing DREM_WIDTH from DATA_WIDTH.
- A single module is used; no sub-module is required. The drop counter may be split out as netcope_drop_cnt if it is reused.

## Test plan
- Frame with a 1-word header (0xA5A5_0000_0000_0001) and a 3-word payload, no stalls. Required response:
  - TX carries 3 words, SOF on word 0 and EOF on word 2, REM unchanged;
  - HDR_DATA=0xA5A5_0000_0000_0001 with a single HDR_VLD pulse.
- Frame with a 2-word header and a 1-word payload (REM=3). Required response:
  - TX emits one word with SOF=SOP=EOP=EOF=0 and REM=3;
  - HDR_DATA equals the first header word.
- Header-only frame. Required response:
  - no TX activity;
  - CNT_DROP goes from 0 to 1;
  - HDR_VLD pulses once.
- Random TX_DST_RDY_N backpressure (50%) over 100 frames. Required response:
  - payload words arrive byte-exact and in order;
  - no SOF appears outside the first payload word;
  - header words are never stalled.
- RESET asserted in the middle of a payload. Required response:
  - outputs return to reset values in the next cycle;
  - the remaining words of the interrupted frame are absorbed;
  - the following frame is stripped correctly.
- CNT_CLR asserted in the same cycle as a header-only EOF transfer, with CNT_DROP=5. Required response: CNT_DROP=0.
